// File: rtl/neuron_sched.sv
// neuron_sched -- control sequencer that time-shares one MAC datapath across
// all neurons of a layer.
//
// For every neuron it clears the accumulator, walks the data/weight pair
// index across all inputs, injects the bias, then writes the activated
// result into the result buffer. After the last neuron it pulses done.
//
// Ports
//   clk_i          clock, all state updates on the rising edge
//   rst_ni         asynchronous active-low reset
//   clk_en_i       global clock enable; state only advances when high
//   start_i        one-cycle layer start request (ignored while busy)
//   abort_i        synchronous cancel of the run in progress
//   pu_result_i    saturated, activated result from the MAC datapath
//   acc_clr_o      accumulator clear strobe
//   use_bias_o     selects bias instead of product at the datapath adder
//   in_addr_o      data/weight pair index
//   neuron_idx_o   current neuron (weight row / bias select)
//   res_we_o, res_addr_o, res_data_o   result-buffer write port
//   busy_o         run in progress (state != IDLE)
//   done_o         one-cycle end-of-layer pulse
//   cycle_cnt_o    enabled busy-cycle counter, saturating at 65535
//                  (present only when NEURON_SCHED_PERF_CNT_EN is defined)
//
// Optional feature macro: NEURON_SCHED_PERF_CNT_EN

module neuron_sched #(
    parameter int N_NEURONS = 30,
    parameter int N_INPUTS  = 62,
    parameter int AW        = 6,
    parameter int NW        = 5,
    parameter int n         = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clk_en_i,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic [n-1:0]  pu_result_i,
    output logic          acc_clr_o,
    output logic          use_bias_o,
    output logic [AW-1:0] in_addr_o,
    output logic [NW-1:0] neuron_idx_o,
    output logic          res_we_o,
    output logic [NW-1:0] res_addr_o,
    output logic [n-1:0]  res_data_o,
    output logic          busy_o,
    output logic          done_o
`ifdef NEURON_SCHED_PERF_CNT_EN
    ,
    output logic [15:0]   cycle_cnt_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_MAC,
        S_BIAS,
        S_WRITE,
        S_DONE
    } state_e;

    localparam logic [AW-1:0] LastAddr = AW'(N_INPUTS - 1);
    localparam logic [NW-1:0] LastIdx  = NW'(N_NEURONS - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] in_addr_q, in_addr_d;
    logic [NW-1:0] neuron_idx_q, neuron_idx_d;

    // State and index registers; everything holds when clk_en_i is low
    // because the next-state logic returns the current values then.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            in_addr_q    <= '0;
            neuron_idx_q <= '0;
        end else begin
            state_q      <= state_d;
            in_addr_q    <= in_addr_d;
            neuron_idx_q <= neuron_idx_d;
        end
    end

    // Next-state logic. Abort has priority over everything, including a
    // start seen in IDLE. The index counters saturate at their last value
    // and are explicitly reloaded rather than wrapping.
    always_comb begin
        state_d      = state_q;
        in_addr_d    = in_addr_q;
        neuron_idx_d = neuron_idx_q;
        if (clk_en_i) begin
            if (abort_i) begin
                state_d      = S_IDLE;
                in_addr_d    = '0;
                neuron_idx_d = '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_i) begin
                            state_d      = S_CLEAR;
                            in_addr_d    = '0;
                            neuron_idx_d = '0;
                        end
                    end
                    S_CLEAR: begin
                        state_d   = S_MAC;
                        in_addr_d = '0;
                    end
                    S_MAC: begin
                        if (in_addr_q == LastAddr) begin
                            state_d = S_BIAS;
                        end else begin
                            in_addr_d = in_addr_q + AW'(1);
                        end
                    end
                    S_BIAS: begin
                        state_d = S_WRITE;
                    end
                    S_WRITE: begin
                        if (neuron_idx_q != LastIdx) begin
                            state_d      = S_CLEAR;
                            in_addr_d    = '0;
                            neuron_idx_d = neuron_idx_q + NW'(1);
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                    S_DONE: begin
                        state_d      = S_IDLE;
                        in_addr_d    = '0;
                        neuron_idx_d = '0;
                    end
                    default: begin
                        state_d      = S_IDLE;
                        in_addr_d    = '0;
                        neuron_idx_d = '0;
                    end
                endcase
            end
        end
    end

    // Strobes are gated by clk_en_i so a stalled cycle never repeats a
    // clear, bias, write or done. An abort in WRITE or DONE suppresses the
    // write/done of that same cycle so a cancelled run leaves no trace.
    always_comb begin
        acc_clr_o  = clk_en_i && (state_q == S_CLEAR);
        use_bias_o = clk_en_i && (state_q == S_BIAS);
        res_we_o   = clk_en_i && !abort_i && (state_q == S_WRITE);
        done_o     = clk_en_i && !abort_i && (state_q == S_DONE);
        res_data_o = res_we_o ? pu_result_i : '0;
    end

    assign in_addr_o    = in_addr_q;
    assign neuron_idx_o = neuron_idx_q;
    assign res_addr_o   = neuron_idx_q;
    assign busy_o       = (state_q != S_IDLE);

`ifdef NEURON_SCHED_PERF_CNT_EN
    logic [15:0] cycle_cnt_q, cycle_cnt_d;

    // Counts enabled busy cycles of the latest run; cleared on an accepted
    // start and left untouched once the run finishes or is aborted.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        if (clk_en_i) begin
            if ((state_q == S_IDLE) && start_i && !abort_i) begin
                cycle_cnt_d = '0;
            end else if ((state_q != S_IDLE) && (cycle_cnt_q != 16'hFFFF)) begin
                cycle_cnt_d = cycle_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycle_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign cycle_cnt_o = cycle_cnt_q;
`endif

endmodule

// File: doc/neuron_sched.md
NEURON_SCHED -- requirements
Module: neuron_sched

Interface
REQ-001 Parameter N_NEURONS, default 30, is the number of neurons of one layer that are time-shared on a single MAC datapath.
REQ-002 Parameter N_INPUTS, default 62, is the number of data/weight pairs per neuron.
REQ-003 Parameter AW, default 6, is the input-address width and SHALL satisfy 2^AW >= N_INPUTS.
REQ-004 Parameter NW, default 5, is the neuron-index width and SHALL satisfy 2^NW >= N_NEURONS.
REQ-005 Parameter n, default 8, is the result data width.
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 clk_en  in  1  global clock enable; state advances only when it is 1.
REQ-009 start  in  1  one-cycle layer start request.
REQ-010 abort  in  1  synchronous cancel of the run in progress.
REQ-011 pu_result  in  n  saturated, activated result from the MAC datapath.
REQ-012 acc_clr  out  1  accumulator clear strobe to the datapath.
REQ-013 use_bias  out  1  selects bias instead of the product at the datapath adder.
REQ-014 in_addr  out  AW  data/weight pair index.
REQ-015 neuron_idx  out  NW  selects the weight row and bias of the current neuron.
REQ-016 res_we, res_addr[NW], res_data[n]  out  result-buffer write port.
REQ-017 busy  out  1  run in progress; done  out  1  one-cycle end-of-layer pulse.

Function
REQ-018 The FSM SHALL have states IDLE, CLEAR, MAC, BIAS, WRITE and DONE; every transition SHALL be qualified by clk_en=1.
REQ-019 IDLE: start=1 SHALL move the FSM to CLEAR with neuron_idx=0.
REQ-020 CLEAR: acc_clr=1 and in_addr=0 for one cycle, then MAC.
REQ-021 MAC: in_addr SHALL step 0..N_INPUTS-1, one value per cycle; at in_addr=N_INPUTS-1 the FSM SHALL go to BIAS.
REQ-022 BIAS: use_bias=1 for one cycle, then WRITE.
REQ-023 WRITE: res_we=1, res_addr=neuron_idx, res_data=pu_result for one cycle.
  - neuron_idx < N_NEURONS-1: increment neuron_idx, go to CLEAR.
  - otherwise: go to DONE.
REQ-024 DONE: done=1 for one cycle, then IDLE; neuron_idx and in_addr return to 0.
REQ-025 Per-neuron latency SHALL be N_INPUTS+3 cycles; a layer run SHALL hold busy=1 for exactly N_NEURONS*(N_INPUTS+3)+1 enabled cycles.
REQ-026 busy SHALL equal (state != IDLE).
REQ-027 start while busy=1 SHALL be ignored and not queued.
REQ-028 abort=1 in any non-IDLE state SHALL force IDLE on the next enabled edge.
  - No further res_we is issued and done is not pulsed.
  - in_addr and neuron_idx are cleared.
REQ-029 abort=1 together with start=1 in IDLE: abort wins and the FSM stays in IDLE.
REQ-030 While clk_en=0, all state SHALL hold, and acc_clr, use_bias, res_we and done SHALL be forced to 0.
REQ-031 in_addr SHALL never exceed N_INPUTS-1 and neuron_idx SHALL never exceed N_NEURONS-1; there is no wrap-around past these limits.

Reset
REQ-032 rst=0 SHALL asynchronously force state=IDLE and set every output to 0: acc_clr, use_bias, in_addr, neuron_idx, res_we, res_addr, res_data, busy, done, and cycle_cnt when present.
REQ-033 Reset asserted mid-run SHALL abandon the run with no write and no done; a fresh start is required after reset releases.

Configuration
REQ-034 Macro NEURON_SCHED_PERF_CNT_EN defined: output cycle_cnt[16] is present.
  - It is cleared when start is accepted.
  - It increments on every enabled busy cycle and saturates at 65535.
  - It holds its value after DONE or abort.
REQ-035 Macro NEURON_SCHED_PERF_CNT_EN undefined: cycle_cnt and its counter logic SHALL be absent; all other behaviour is identical.

Verification (bench parameters N_NEURONS=3, N_INPUTS=4, clk_en=1 unless stated)
REQ-036 Basic run: start pulse with pu_result driven to 0x11, 0x22, 0x33 at each WRITE.
  - Response: busy high for 22 cycles.
  - in_addr sequence 0,1,2,3 for each neuron.
  - Writes (0,0x11), (1,0x22), (2,0x33), then a single done pulse.
REQ-037 Abort: abort during neuron 1 MAC with in_addr=2.
  - Response: IDLE next cycle, busy=0, no write to addr 1 or 2, no done.
REQ-038 Stall: clk_en=0 for 5 cycles in BIAS.
  - Response: state and outputs frozen, use_bias=0 during the stall.
  - Resumes with use_bias=1 for one enabled cycle; total enabled busy cycles still 22.
REQ-039 Start while busy, and start+abort in IDLE.
  - start re-pulsed during MAC: run unchanged.
  - start and abort together in IDLE: busy stays 0.
REQ-040 Reset mid-run: rst=0 during neuron 2 CLEAR.
  - Response: all outputs 0 immediately, asynchronously; no done.
REQ-041 With NEURON_SCHED_PERF_CNT_EN: after the basic run, cycle_cnt=22; after the abort scenario, cycle_cnt equals the number of busy cycles elapsed before the abort.
